// File: rtl/nios2_system_v0_pio_pkg.sv
// nios2_system_v0_pio_pkg: register addresses and pulse FSM states shared by the PIO blocks
package nios2_system_v0_pio_pkg;
  localparam logic [2:0] ADDR_DATA      = 3'd0;
  localparam logic [2:0] ADDR_PULSE_LEN = 3'd2;
  localparam logic [2:0] ADDR_PULSE     = 3'd3;
  localparam logic [2:0] ADDR_OUTSET    = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR  = 3'd5;
  typedef enum logic {PULSE_IDLE, PULSE_ACTIVE} pulse_state_e;
endpackage

// File: rtl/nios2_system_v0_pio_pulse_timer.sv
// nios2_system_v0_pio_pulse_timer: loadable down-counter that strobes expire on its 1->0 step
module nios2_system_v0_pio_pulse_timer
  import nios2_system_v0_pio_pkg::*;
#(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 load,
  input  logic                 cancel,
  input  logic [CNT_WIDTH-1:0] len,
  output logic                 expire
);
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  pulse_state_e state_q, state_d;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      state_q <= PULSE_IDLE;
    end else begin
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end
  always_comb begin
    cnt_d   = load ? len : (cancel || state_q == PULSE_IDLE) ? '0 : cnt_q - CNT_WIDTH'(1);
    state_d = (cnt_d != '0) ? PULSE_ACTIVE : PULSE_IDLE;
  end
  always_comb begin
    expire = state_q == PULSE_ACTIVE && cnt_q == CNT_WIDTH'(1);
  end
endmodule

// File: rtl/nios2_system_v0_led_pio.sv
// nios2_system_v0_led_pio: Avalon-MM LED output port with set/clear and self-clearing pulse bits
module nios2_system_v0_led_pio
  import nios2_system_v0_pio_pkg::*;
#(
  parameter int                    DATA_WIDTH      = 8,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE     = '0,
  parameter int                    PULSE_CNT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic [DATA_WIDTH-1:0] out_port
);
  localparam int UW = DATA_WIDTH > PULSE_CNT_WIDTH ? DATA_WIDTH : PULSE_CNT_WIDTH;
  logic [DATA_WIDTH-1:0] data_q, data_d, mask_q, mask_d, data_e, mask_e, wd;
  logic [PULSE_CNT_WIDTH-1:0] len_q, len_d;
  logic [31:0] readdata_d;
  logic wr, load, cancel, expire, unused_wd;
  assign unused_wd = ^writedata[31:UW];
  assign wr     = chipselect & ~write_n;
  assign wd     = writedata[DATA_WIDTH-1:0];
  assign data_e = expire ? data_q & ~mask_q : data_q;
  assign mask_e = expire ? '0 : mask_q;
  // Bus writes are applied on top of the post-expiry view so expiry resolves first
  always_comb begin
    data_d = data_e;
    mask_d = mask_e;
    len_d  = len_q;
    load   = 1'b0;
    cancel = 1'b0;
    if (wr) begin
      case (address)
        ADDR_DATA: begin
          data_d = wd;
          mask_d = '0;
          cancel = 1'b1;
        end
        ADDR_PULSE_LEN: len_d = writedata[PULSE_CNT_WIDTH-1:0];
        ADDR_PULSE: if (len_q != '0) begin
          data_d = (data_e & ~mask_e) | wd;
          mask_d = wd;
          load   = 1'b1;
        end
        ADDR_OUTSET: begin
          data_d = data_e | wd;
          mask_d = mask_e & ~wd;
          cancel = mask_d == '0;
        end
        ADDR_OUTCLEAR: begin
          data_d = data_e & ~wd;
          mask_d = mask_e & ~wd;
          cancel = mask_d == '0;
        end
        default: ;
      endcase
    end
  end
  always_comb begin
    readdata_d = address == ADDR_DATA      ? 32'(data_q) :
                 address == ADDR_PULSE_LEN ? 32'(len_q)  :
                 address == ADDR_PULSE     ? 32'(mask_q) : '0;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q   <= RESET_VALUE;
      mask_q   <= '0;
      len_q    <= '0;
      readdata <= '0;
    end else begin
      data_q   <= data_d;
      mask_q   <= mask_d;
      len_q    <= len_d;
      readdata <= readdata_d;
    end
  end
  assign out_port = data_q;
  nios2_system_v0_pio_pulse_timer #(.CNT_WIDTH(PULSE_CNT_WIDTH)) u_timer (
    .clk    (clk),
    .reset_n(reset_n),
    .load   (load),
    .cancel (cancel),
    .len    (len_q),
    .expire (expire)
  );
endmodule
